// File: rtl/bit_sync_updown_counter.sv
// Parametrised up/down counter with modulus, parallel load, wrap/saturate mode,
// combinational terminal count for cascading and a registered boundary pulse.
module bit_sync_updown_counter #(
    parameter int N        = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic         CLK,
    input  logic         EN,
    input  logic         CE,
    input  logic         UP,
    input  logic         LD,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         TC,
    output logic         OVF
);

    localparam logic [N-1:0] MAX = N'(MODULUS - 1);

    logic [N-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (cnt_q == MAX);
    assign at_zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (LD) begin
            // Out-of-range load values clamp so Q can never exceed MAX.
            cnt_d = (D > MAX) ? MAX : D;
        end else if (CE) begin
            if (UP) begin
                if (!at_max) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    if (SATURATE == 0) begin
                        cnt_d = '0;
                    end
                end
            end else begin
                if (!at_zero) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ovf_d = 1'b1;
                    if (SATURATE == 0) begin
                        cnt_d = MAX;
                    end
                end
            end
        end
    end

    // EN doubles as the asynchronous active-low clear.
    always_ff @(posedge CLK or negedge EN) begin
        if (!EN) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Zero-latency terminal count; gated by EN so a cleared stage never enables its successor.
    assign TC  = EN & CE & ~LD & ((UP & at_max) | (~UP & at_zero));
    assign Q   = cnt_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_bit_sync_updown_counter.sv
// Directed bench: wrap, saturate, full-modulus and cascaded counters with
// table-driven vectors and hand-written multi-cycle sequences.
module tb_bit_sync_updown_counter;

    typedef struct packed {
        logic       ce;
        logic       up;
        logic       ld;
        logic [3:0] d;
        logic [3:0] q;
        logic       tc;
        logic       ovf;
    } vec_t;

    logic       CLK;
    logic       EN;
    logic       CE;
    logic       UP;
    logic       LD;
    logic [3:0] D;
    logic       en_c;

    logic [3:0] q_w, q_s, q_f, q0, q1;
    logic       tc_w, tc_s, tc_f, tc0, tc1;
    logic       ovf_w, ovf_s, ovf_f, ovf0, ovf1;

    int errors;
    int checks;

    vec_t vecs[$];

    bit_sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .CLK(CLK), .EN(EN), .CE(CE), .UP(UP), .LD(LD), .D(D),
        .Q(q_w), .TC(tc_w), .OVF(ovf_w)
    );

    bit_sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .CLK(CLK), .EN(EN), .CE(CE), .UP(UP), .LD(LD), .D(D),
        .Q(q_s), .TC(tc_s), .OVF(ovf_s)
    );

    bit_sync_updown_counter #(.N(4), .MODULUS(16), .SATURATE(0)) u_full (
        .CLK(CLK), .EN(EN), .CE(CE), .UP(UP), .LD(LD), .D(D),
        .Q(q_f), .TC(tc_f), .OVF(ovf_f)
    );

    bit_sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(0)) u_c0 (
        .CLK(CLK), .EN(en_c), .CE(1'b1), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(q0), .TC(tc0), .OVF(ovf0)
    );

    bit_sync_updown_counter #(.N(4), .MODULUS(10), .SATURATE(0)) u_c1 (
        .CLK(CLK), .EN(en_c), .CE(tc0), .UP(1'b1), .LD(1'b0), .D(4'd0),
        .Q(q1), .TC(tc1), .OVF(ovf1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic ce, input logic up, input logic ld, input logic [3:0] d,
                       input logic [3:0] q, input logic tc, input logic ovf);
        vec_t v;
        v.ce = ce; v.up = up; v.ld = ld; v.d = d;
        v.q = q; v.tc = tc; v.ovf = ovf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic ce, input logic up, input logic ld, input logic [3:0] d);
        CE = ce; UP = up; LD = ld; D = d;
    endtask

    initial begin
        int exp_v;
        int sq[5];
        int sovf[5];
        errors = 0;
        checks = 0;

        // Wrap-mode vectors: count up 0..9 and wrap
        for (int i = 1; i <= 12; i++) begin
            add(1, 1, 0, 0, 4'((i % 10)), (i % 10) == 9, (i == 10));
        end
        // Load 3, count down through 0 to 8
        add(0, 0, 1, 3,  3, 0, 0);
        add(1, 0, 0, 0,  2, 0, 0);
        add(1, 0, 0, 0,  1, 0, 0);
        add(1, 0, 0, 0,  0, 1, 0);
        add(1, 0, 0, 0,  9, 0, 1);
        add(1, 0, 0, 0,  8, 0, 0);
        // Clamped load, load beats count, hold, reversal at MAX
        add(0, 0, 1, 14, 9, 0, 0);
        add(1, 1, 1, 5,  5, 0, 0);
        add(0, 1, 0, 0,  5, 0, 0);
        add(0, 0, 1, 15, 9, 0, 0);
        add(1, 0, 0, 0,  8, 0, 0);
        add(1, 1, 0, 0,  9, 1, 0);
        add(1, 0, 0, 0,  8, 0, 0);

        EN = 1'b0; en_c = 1'b0;
        drive(1, 0, 0, 0);
        #2;
        chk("reset_q", 32'(q_w), 0);
        chk("reset_ovf", 32'(ovf_w), 0);
        chk("reset_tc_gated", 32'(tc_w), 0);
        #10;
        EN = 1'b1;
        drive(1, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ce, vecs[i].up, vecs[i].ld, vecs[i].d);
            step();
            chk($sformatf("vec%0d_q", i), 32'(q_w), 32'(vecs[i].q));
            chk($sformatf("vec%0d_tc", i), 32'(tc_w), 32'(vecs[i].tc));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_w), 32'(vecs[i].ovf));
        end

        // Saturate mode: count up from 7 into the top bound
        drive(0, 1, 1, 7);
        step();
        chk("sat_load7", 32'(q_s), 7);
        sq   = '{8, 9, 9, 9, 9};
        sovf = '{0, 0, 1, 1, 1};
        drive(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat_up%0d_q", i), 32'(q_s), 32'(sq[i]));
            chk($sformatf("sat_up%0d_ovf", i), 32'(ovf_s), 32'(sovf[i]));
            chk($sformatf("sat_up%0d_tc", i), 32'(tc_s), 32'(sq[i] == 9));
        end
        drive(0, 1, 0, 0);
        step();
        chk("sat_hold_q", 32'(q_s), 9);
        chk("sat_hold_ovf", 32'(ovf_s), 0);
        // Saturate at the bottom bound
        drive(0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("sat_dn%0d_q", i), 32'(q_s), 0);
            chk($sformatf("sat_dn%0d_ovf", i), 32'(ovf_s), 1);
            chk($sformatf("sat_dn%0d_tc", i), 32'(tc_s), 1);
        end
        drive(1, 1, 0, 0);
        step();
        chk("sat_rev_q", 32'(q_s), 1);
        chk("sat_rev_ovf", 32'(ovf_s), 0);

        // Full modulus: natural 4-bit wrap both ways
        drive(0, 1, 1, 15);
        step();
        chk("full_load15", 32'(q_f), 15);
        drive(1, 1, 0, 0);
        step();
        chk("full_up_wrap_q", 32'(q_f), 0);
        chk("full_up_wrap_ovf", 32'(ovf_f), 1);
        drive(1, 0, 0, 0);
        step();
        chk("full_dn_wrap_q", 32'(q_f), 15);
        chk("full_dn_wrap_ovf", 32'(ovf_f), 1);
        step();
        chk("full_dn_q", 32'(q_f), 14);
        chk("full_dn_ovf", 32'(ovf_f), 0);

        // Asynchronous clear mid-count at Q=6
        drive(0, 1, 1, 5);
        step();
        drive(1, 1, 0, 0);
        step();
        chk("mid_q6", 32'(q_w), 6);
        #2;
        EN = 1'b0;
        UP = 1'b0;
        #1;
        chk("async_clr_q", 32'(q_w), 0);
        chk("async_clr_ovf", 32'(ovf_w), 0);
        chk("async_clr_tc", 32'(tc_w), 0);
        step();
        chk("clr_held_q", 32'(q_w), 0);
        EN = 1'b1;
        UP = 1'b1;
        step();
        chk("after_clr_q", 32'(q_w), 1);
        // Clear while OVF is high drops the pulse immediately
        drive(0, 1, 1, 9);
        step();
        drive(1, 1, 0, 0);
        step();
        chk("pre_clr_ovf", 32'(ovf_w), 1);
        #2;
        EN = 1'b0;
        #1;
        chk("clr_drops_ovf", 32'(ovf_w), 0);
        #3;
        EN = 1'b1;
        drive(0, 1, 0, 0);

        // Cascade of two decade stages counting 00..99..00
        @(posedge CLK);
        #3;
        en_c = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            exp_v = (i + 1) % 100;
            chk($sformatf("casc%0d", i), {24'd0, q1, q0}, 32'({4'(exp_v / 10), 4'(exp_v % 10)}));
            chk($sformatf("casc%0d_tc1", i), 32'(tc1), 32'(exp_v == 99));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
